// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative comparator and the downstream comparison decoder.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } cmp_state_e;

    localparam logic [2:0] CMP_GT = 3'b000;
    localparam logic [2:0] CMP_GE = 3'b001;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_LE = 3'b011;
    localparam logic [2:0] CMP_EQ = 3'b100;
    localparam logic [2:0] CMP_NE = 3'b101;

    // Counter width for n digits; kept at least 1 bit so a single-digit build still elaborates.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module cmp_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    output logic             lt,
    output logic             eq
);

    assign lt = (da < db);
    assign eq = (da == db);

endmodule

// File: rtl/cmp_iter.sv
// Iterative MSB-first magnitude comparator, DIGIT bits per cycle with early exit on a difference.
module cmp_iter
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic [2:0]       ctrl_in,
    output logic             busy,
    output logic             done,
    output logic             less_out,
    output logic             eql_out,
    output logic [2:0]       ctrl_out
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = cnt_width(N);
    localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       ctrl_p_q, ctrl_p_d;
    logic [2:0]       ctrl_out_q, ctrl_out_d;
    logic             less_q, less_d, eql_q, eql_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             dig_lt, dig_eq;

    cmp_digit #(
        .DIGIT(DIGIT)
    ) u_cmp_digit (
        .da(sa_q[WIDTH-1 -: DIGIT]),
        .db(sb_q[WIDTH-1 -: DIGIT]),
        .lt(dig_lt),
        .eq(dig_eq)
    );

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        ctrl_p_d   = ctrl_p_q;
        ctrl_out_d = ctrl_out_q;
        less_d     = less_q;
        eql_d      = eql_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    sa_d             = a;
                    sb_d             = b;
                    sa_d[WIDTH-1]    = a[WIDTH-1] ^ is_signed;
                    sb_d[WIDTH-1]    = b[WIDTH-1] ^ is_signed;
                    ctrl_p_d         = ctrl_in;
                    cnt_d            = '0;
                    state_d          = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (!dig_eq) begin
                    less_d     = dig_lt;
                    eql_d      = 1'b0;
                    ctrl_out_d = ctrl_p_q;
                    state_d    = DONE;
                end else if (cnt_q == CntMax) begin
                    less_d     = 1'b0;
                    eql_d      = 1'b1;
                    ctrl_out_d = ctrl_p_q;
                    state_d    = DONE;
                end else begin
                    sa_d  = sa_q << DIGIT;
                    sb_d  = sb_q << DIGIT;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SCAN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sa_q       <= '0;
            sb_q       <= '0;
            cnt_q      <= '0;
            ctrl_p_q   <= '0;
            ctrl_out_q <= '0;
            less_q     <= 1'b0;
            eql_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            cnt_q      <= cnt_d;
            ctrl_p_q   <= ctrl_p_d;
            ctrl_out_q <= ctrl_out_d;
            less_q     <= less_d;
            eql_q      <= eql_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign less_out = less_q;
    assign eql_out  = eql_q;
    assign ctrl_out = ctrl_out_q;

endmodule

// File: tb/tb_cmp_iter.sv
// Directed bench for cmp_iter: latency, signed/unsigned results, busy/start handling and reset abort.
module tb_cmp_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        is_signed;
    logic [2:0]  ctrl_in;
    logic        busy, done, less_out, eql_out;
    logic [2:0]  ctrl_out;

    int n_chk = 0;
    int n_bad = 0;

    cmp_iter #(
        .WIDTH(32),
        .DIGIT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .is_signed(is_signed),
        .ctrl_in  (ctrl_in),
        .busy     (busy),
        .done     (done),
        .less_out (less_out),
        .eql_out  (eql_out),
        .ctrl_out (ctrl_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start in cycle T, then sample each following cycle until done (bounded).
    // lat is the done cycle relative to T; bcnt counts busy cycles seen before done.
    task automatic run_cmp(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                           input logic [2:0] ct, output int lat, output int bcnt);
        a = av; b = bv; is_signed = sg; ctrl_in = ct; start = 1'b1;
        tick();
        start = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    int lat, bcnt, seen_done;

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0; ctrl_in = '0;
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_less", 32'(less_out), 0);
        check("rst_eql", 32'(eql_out), 0);
        check("rst_ctrl", 32'(ctrl_out), 0);
        rst_n = 1'b1;
        tick();

        // Unsigned, difference only in the last digit.
        run_cmp(32'h0000_0005, 32'h0000_0007, 1'b0, 3'b010, lat, bcnt);
        check("far_lat", lat, 9);
        check("far_busy", bcnt, 8);
        check("far_less", 32'(less_out), 1);
        check("far_eql", 32'(eql_out), 0);
        check("far_ctrl", 32'(ctrl_out), 32'h2);
        tick();
        check("far_done_pulse", 32'(done), 0);
        check("far_less_held", 32'(less_out), 1);

        // Top-digit early exit, unsigned then signed.
        run_cmp(32'h8000_0000, 32'h0000_0001, 1'b0, 3'b000, lat, bcnt);
        check("top_u_lat", lat, 2);
        check("top_u_less", 32'(less_out), 0);
        check("top_u_eql", 32'(eql_out), 0);
        tick();
        run_cmp(32'h8000_0000, 32'h0000_0001, 1'b1, 3'b000, lat, bcnt);
        check("top_s_lat", lat, 2);
        check("top_s_less", 32'(less_out), 1);
        tick();

        // Equal operands.
        run_cmp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b101, lat, bcnt);
        check("eq_lat", lat, 9);
        check("eq_eql", 32'(eql_out), 1);
        check("eq_less", 32'(less_out), 0);
        check("eq_ctrl", 32'(ctrl_out), 32'h5);
        tick();

        // Start during SCAN is ignored; start in the DONE cycle is accepted.
        a = 32'h0000_0007; b = 32'h0000_0005; is_signed = 1'b0; ctrl_in = 3'b001; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 32'h0; b = 32'h1; ctrl_in = 3'b011; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 4;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("ign_lat", lat, 9);
        check("ign_less", 32'(less_out), 0);
        check("ign_eql", 32'(eql_out), 0);
        check("ign_ctrl", 32'(ctrl_out), 32'h1);
        a = 32'h0000_0000; b = 32'h1000_0000; ctrl_in = 3'b110; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_done", 32'(done), 0);
        check("b2b_hold_ctrl", 32'(ctrl_out), 32'h1);
        tick();
        check("b2b_done2", 32'(done), 1);
        check("b2b_less", 32'(less_out), 1);
        check("b2b_ctrl", 32'(ctrl_out), 32'h6);
        tick();

        // Reset in cycle T+4 of an equal-operand compare aborts it.
        seen_done = 0;
        a = 32'h1234_5678; b = 32'h1234_5678; ctrl_in = 3'b100; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) seen_done = 1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        check("rmid_busy", 32'(busy), 0);
        check("rmid_done", 32'(done), 0);
        check("rmid_less", 32'(less_out), 0);
        check("rmid_eql", 32'(eql_out), 0);
        check("rmid_ctrl", 32'(ctrl_out), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done) seen_done = 1;
            tick();
        end
        check("rmid_no_done", seen_done, 0);

        // Signed negative pair: -2 < -1.
        run_cmp(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 3'b010, lat, bcnt);
        check("neg_lat", lat, 9);
        check("neg_less", 32'(less_out), 1);
        check("neg_eql", 32'(eql_out), 0);
        tick();

        // Signed positive vs negative: 1 > -1.
        run_cmp(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 3'b000, lat, bcnt);
        check("pn_lat", lat, 2);
        check("pn_less", 32'(less_out), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
